// File: rtl/mvau_stream_ctrl_pkg.sv
// Shared widths, tile types and sizing helpers for the streaming-weight MVU front end.
package mvau_stream_ctrl_pkg;

  localparam int unsigned SIMD  = 2;
  localparam int unsigned PE    = 2;
  localparam int unsigned TW    = 4;
  localparam int unsigned TA    = 4;
  localparam int unsigned ACC_W = 16;

  localparam int unsigned TI  = SIMD * TA;
  localparam int unsigned TWT = PE * SIMD * TW;
  localparam int unsigned TO  = PE * ACC_W;

  typedef logic [TI-1:0]  act_tile_t;
  typedef logic [TWT-1:0] wgt_tile_t;
  typedef logic [TO-1:0]  res_t;

  // Result FIFO must absorb everything in flight through the datapath plus one.
  function automatic int unsigned fifo_depth(input int unsigned pipe_lat);
    return pipe_lat + 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvau_stream_ctrl_if.sv
// Activation/weight input streams, datapath tile bus and result stream of the MVU controller.
interface mvau_stream_ctrl_if;
  import mvau_stream_ctrl_pkg::*;

  logic      in_v;
  logic      in_rdy;
  act_tile_t in_act;
  logic      wgt_v;
  logic      wgt_rdy;
  wgt_tile_t in_wgt;
  logic      sf_clr;
  act_tile_t mv_act;
  wgt_tile_t mv_wgt;
  res_t      mv_out;
  logic      out_v;
  logic      out_rdy;
  res_t      out;

  modport slave (
    input  in_v, in_act, wgt_v, in_wgt, mv_out, out_rdy,
    output in_rdy, wgt_rdy, sf_clr, mv_act, mv_wgt, out_v, out
  );

  modport master (
    output in_v, in_act, wgt_v, in_wgt, mv_out, out_rdy,
    input  in_rdy, wgt_rdy, sf_clr, mv_act, mv_wgt, out_v, out
  );

endinterface

// File: rtl/mvau_stream_ctrl_out_fifo.sv
// Shift-style result FIFO: entry 0 is the registered head; unused entries are held at zero.
module mvau_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [CW-1:0]    cnt;
  logic             pop_fire;
  logic [AW-1:0]    wr_idx;

  always_comb begin
    pop_fire = pop && (cnt != '0);
    wr_idx   = pop_fire ? AW'(cnt - 1'b1) : AW'(cnt);
    mem_n    = mem;
    if (pop_fire) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        mem_n[i] = mem[i+1];
      end
      mem_n[DEPTH-1] = '0;
    end
    // Write slot accounts for the shift so push+pop keeps order.
    if (push) begin
      mem_n[wr_idx] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      cnt <= '0;
    end else begin
      mem <= mem_n;
      unique case ({push, pop_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[0];
  assign count = cnt;

endmodule

// File: rtl/mvau_stream_ctrl.sv
// Sequences SF x NF folds over activation/weight streams, reusing buffered activations
// across neuron folds, and collects fold results into a credit-protected output FIFO.
module mvau_stream_ctrl
  import mvau_stream_ctrl_pkg::*;
#(
  parameter int unsigned SF       = 4,
  parameter int unsigned NF       = 3,
  parameter int unsigned PIPE_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mvau_stream_ctrl_if.slave bus
);

  localparam int unsigned D   = fifo_depth(PIPE_LAT);
  localparam int unsigned SFW = cnt_w(SF);
  localparam int unsigned NFW = cnt_w(NF);
  localparam int unsigned CRW = $clog2(D + 1);

  logic [SFW-1:0]  sf_cnt;
  logic [NFW-1:0]  nf_cnt;
  logic [CRW-1:0]  credits;
  act_tile_t       act_buf [SF];
  logic [PIPE_LAT:0] marker;

  logic      first_nf;
  logic      last_sf;
  logic      last_nf;
  logic      act_ok;
  logic      credit_ok;
  logic      fire;
  logic      last_fire;
  logic      pop;
  logic      fifo_v;
  act_tile_t act_sel;
  res_t      fifo_head;
  logic [CRW-1:0] fifo_count;

  logic      sf_clr_q;
  act_tile_t mv_act_q;
  wgt_tile_t mv_wgt_q;

  always_comb begin
    first_nf  = (nf_cnt == '0);
    last_sf   = (sf_cnt == SFW'(SF - 1));
    last_nf   = (nf_cnt == NFW'(NF - 1));
    act_ok    = first_nf ? bus.in_v : 1'b1;
    // Only the tile that closes a fold needs a FIFO slot reserved.
    credit_ok = !last_sf || (credits != '0);
    fire      = !rst && act_ok && bus.wgt_v && credit_ok;
    last_fire = fire && last_sf;
    act_sel   = first_nf ? bus.in_act : act_buf[sf_cnt];
  end

  assign bus.wgt_rdy = !rst && act_ok && credit_ok;
  assign bus.in_rdy  = !rst && first_nf && bus.wgt_v && credit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sf_cnt <= '0;
      nf_cnt <= '0;
    end else if (fire) begin
      if (last_sf) begin
        sf_cnt <= '0;
        nf_cnt <= last_nf ? '0 : nf_cnt + 1'b1;
      end else begin
        sf_cnt <= sf_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SF; i++) begin
        act_buf[i] <= '0;
      end
    end else if (fire && first_nf) begin
      act_buf[sf_cnt] <= bus.in_act;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRW'(D);
    end else begin
      unique case ({last_fire, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Idle cycles drive zero tiles so the datapath accumulator simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      sf_clr_q <= 1'b0;
      mv_act_q <= '0;
      mv_wgt_q <= '0;
    end else begin
      sf_clr_q <= fire && (sf_cnt == '0);
      mv_act_q <= fire ? act_sel : '0;
      mv_wgt_q <= fire ? bus.in_wgt : '0;
    end
  end

  assign bus.sf_clr = sf_clr_q;
  assign bus.mv_act = mv_act_q;
  assign bus.mv_wgt = mv_wgt_q;

  // marker[k] set means a fold's last tile was on mv_* k cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      marker <= '0;
    end else begin
      marker <= {marker[PIPE_LAT-1:0], last_fire};
    end
  end

  mvau_out_fifo #(
    .DEPTH (D),
    .WIDTH (TO)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (marker[PIPE_LAT]),
    .push_data (bus.mv_out),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign fifo_v    = (fifo_count != '0);
  assign pop       = fifo_v && bus.out_rdy;
  assign bus.out_v = fifo_v;
  assign bus.out   = fifo_head;

endmodule

// File: tb/tb_mvau_stream_ctrl.sv
// Directed bench for mvau_stream_ctrl with a behavioural accumulate datapath (PIPE_LAT=2).
module tb_mvau_stream_ctrl;
  import mvau_stream_ctrl_pkg::*;

  localparam int unsigned SF       = 4;
  localparam int unsigned NF       = 3;
  localparam int unsigned PIPE_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvau_stream_ctrl_if bus ();

  mvau_stream_ctrl #(
    .SF       (SF),
    .NF       (NF),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Datapath: accumulate stage plus one output stage gives PIPE_LAT=2.
  res_t dp_acc  = '0;
  res_t dp_pipe = '0;

  function automatic res_t dp_step(res_t acc, logic clr, act_tile_t a, wgt_tile_t w);
    res_t r;
    logic [ACC_W-1:0] s;
    r = '0;
    for (int unsigned p = 0; p < PE; p++) begin
      s = clr ? '0 : acc[p*ACC_W +: ACC_W];
      for (int unsigned k = 0; k < SIMD; k++) begin
        s = s + ACC_W'(a[k*TA +: TA]) * ACC_W'(w[(p*SIMD+k)*TW +: TW]);
      end
      r[p*ACC_W +: ACC_W] = s;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    dp_acc  <= dp_step(dp_acc, bus.sf_clr, bus.mv_act, bus.mv_wgt);
    dp_pipe <= dp_acc;
  end
  assign bus.mv_out = dp_pipe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  act_tile_t acts[$];
  wgt_tile_t wgts[$];
  res_t      got[$];
  int        fire_cyc[$];
  int        clr_cyc[$];
  int        n_act, n_inrdy, n_idle, mv_bad, first_outv;
  logic      prev_fire = 1'b0;
  wgt_tile_t prev_wgt  = '0;

  task automatic clear_stats();
    got.delete();
    fire_cyc.delete();
    clr_cyc.delete();
    n_act      = 0;
    n_inrdy    = 0;
    n_idle     = 0;
    mv_bad     = 0;
    first_outv = -1;
  endtask

  // One clock: drive at negedge, observe 1 ns later, log handshakes.
  task automatic tick(input logic r, input logic av, input logic wv, input logic ordy);
    @(negedge clk);
    rst         = r;
    bus.in_v    = av && (acts.size() != 0);
    bus.in_act  = (acts.size() != 0) ? acts[0] : '0;
    bus.wgt_v   = wv && (wgts.size() != 0);
    bus.in_wgt  = (wgts.size() != 0) ? wgts[0] : '0;
    bus.out_rdy = ordy;
    #1;
    cyc++;
    if (prev_fire) begin
      if (bus.mv_wgt !== prev_wgt) mv_bad++;
    end else begin
      n_idle++;
      if (bus.mv_wgt !== '0 || bus.mv_act !== '0 || bus.sf_clr !== 1'b0) mv_bad++;
    end
    if (bus.sf_clr === 1'b1) clr_cyc.push_back(cyc);
    if (bus.out_v === 1'b1 && first_outv < 0) first_outv = cyc;
    if (bus.out_v === 1'b1 && bus.out_rdy === 1'b1) got.push_back(bus.out);
    if (bus.in_rdy === 1'b1) n_inrdy++;
    if (bus.in_v === 1'b1 && bus.in_rdy === 1'b1) begin
      void'(acts.pop_front());
      n_act++;
    end
    prev_fire = (bus.wgt_v === 1'b1) && (bus.wgt_rdy === 1'b1);
    if (prev_fire) begin
      prev_wgt = bus.in_wgt;
      fire_cyc.push_back(cyc);
      void'(wgts.pop_front());
    end
  endtask

  // nvec activation vectors of all-ones; fold j uses weight value j+1.
  task automatic load_folds(input int nvec);
    logic [TW-1:0] w4;
    for (int v = 0; v < nvec; v++) begin
      repeat (SF) acts.push_back(8'h11);
    end
    for (int j = 0; j < nvec * NF; j++) begin
      w4 = TW'(j + 1);
      repeat (SF) wgts.push_back({(PE*SIMD){w4}});
    end
  endtask

  task automatic test_reset();
    acts.push_back(8'h11);
    wgts.push_back(16'h1111);
    tick(1, 1, 1, 1);
    checks++; if (bus.in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0", bus.in_rdy); end
    checks++; if (bus.wgt_rdy !== 1'b0) begin errors++; $display("FAIL reset_wgt_rdy: got %b expected 0", bus.wgt_rdy); end
    tick(1, 1, 1, 1);
    checks++; if (bus.sf_clr !== 1'b0) begin errors++; $display("FAIL reset_sf_clr: got %b expected 0", bus.sf_clr); end
    checks++; if (bus.mv_act !== '0) begin errors++; $display("FAIL reset_mv_act: got %h expected 0", bus.mv_act); end
    checks++; if (bus.mv_wgt !== '0) begin errors++; $display("FAIL reset_mv_wgt: got %h expected 0", bus.mv_wgt); end
    checks++; if (bus.out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v: got %b expected 0", bus.out_v); end
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    acts.delete();
    wgts.delete();
  endtask

  task automatic test_stream();
    clear_stats();
    repeat (4) acts.push_back(8'h11);
    repeat (12) wgts.push_back(16'h1111);
    for (int i = 0; i < 60 && !(fire_cyc.size() == 12 && got.size() == 3); i++) tick(0, 1, 1, 1);
    checks++; if (fire_cyc.size() != 12) begin errors++; $display("FAIL stream_fires: got %0d expected 12", fire_cyc.size()); end
    if (fire_cyc.size() == 12) begin
      checks++; if (fire_cyc[11] - fire_cyc[0] != 11) begin errors++; $display("FAIL stream_span: got %0d expected 11", fire_cyc[11] - fire_cyc[0]); end
      checks++; if (first_outv != fire_cyc[3] + 4) begin errors++; $display("FAIL stream_latency: got %0d expected %0d", first_outv, fire_cyc[3] + 4); end
    end
    checks++; if (n_inrdy != 4) begin errors++; $display("FAIL stream_in_rdy_cycles: got %0d expected 4", n_inrdy); end
    checks++; if (clr_cyc.size() != 3) begin errors++; $display("FAIL stream_clr_count: got %0d expected 3", clr_cyc.size()); end
    if (clr_cyc.size() == 3 && fire_cyc.size() == 12) begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (clr_cyc[f] != fire_cyc[4*f] + 1) begin errors++; $display("FAIL stream_clr_pos%0d: got %0d expected %0d", f, clr_cyc[f], fire_cyc[4*f] + 1); end
      end
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stream_results: got %0d expected 3", got.size()); end
    for (int f = 0; f < got.size(); f++) begin
      checks++; if (got[f] !== 32'h0008_0008) begin errors++; $display("FAIL stream_val%0d: got %h expected 00080008", f, got[f]); end
    end
    checks++; if (mv_bad != 0) begin errors++; $display("FAIL stream_mv_bus: got %0d bad cycles expected 0", mv_bad); end
  endtask

  task automatic test_weights_k();
    res_t exp3 [3];
    exp3 = '{32'h0018_0018, 32'h0024_0024, 32'h0030_0030};
    clear_stats();
    acts.push_back(8'h11); acts.push_back(8'h22); acts.push_back(8'h11); acts.push_back(8'h22);
    repeat (4) wgts.push_back(16'h2222);
    repeat (4) wgts.push_back(16'h3333);
    repeat (4) wgts.push_back(16'h4444);
    for (int i = 0; i < 60 && !(fire_cyc.size() == 12 && got.size() == 3); i++) tick(0, 1, 1, 1);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL wk_results: got %0d expected 3", got.size()); end
    for (int f = 0; f < got.size() && f < 3; f++) begin
      checks++; if (got[f] !== exp3[f]) begin errors++; $display("FAIL wk_val%0d: got %h expected %h", f, got[f], exp3[f]); end
    end
  endtask

  task automatic test_toggle();
    clear_stats();
    repeat (4) acts.push_back(8'h11);
    repeat (12) wgts.push_back(16'h1111);
    for (int i = 0; i < 80 && !(fire_cyc.size() == 12 && got.size() == 3); i++) tick(0, 1, (i % 2) == 0, 1);
    checks++; if (fire_cyc.size() != 12) begin errors++; $display("FAIL toggle_fires: got %0d expected 12", fire_cyc.size()); end
    if (fire_cyc.size() == 12) begin
      checks++; if (fire_cyc[11] - fire_cyc[0] != 22) begin errors++; $display("FAIL toggle_span: got %0d expected 22", fire_cyc[11] - fire_cyc[0]); end
    end
    checks++; if (mv_bad != 0) begin errors++; $display("FAIL toggle_mv_idle: got %0d bad cycles expected 0", mv_bad); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL toggle_results: got %0d expected 3", got.size()); end
    for (int f = 0; f < got.size(); f++) begin
      checks++; if (got[f] !== 32'h0008_0008) begin errors++; $display("FAIL toggle_val%0d: got %h expected 00080008", f, got[f]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    repeat (4) acts.push_back(8'h11);
    repeat (12) wgts.push_back(16'h1111);
    for (int i = 0; i < 20 && fire_cyc.size() < 7; i++) tick(0, 1, 1, 0);
    checks++; if (fire_cyc.size() != 7) begin errors++; $display("FAIL rmid_pre_fires: got %0d expected 7", fire_cyc.size()); end
    repeat (3) tick(0, 0, 0, 0);
    checks++; if (bus.out_v !== 1'b1) begin errors++; $display("FAIL rmid_pre_out_v: got %b expected 1", bus.out_v); end
    tick(1, 0, 0, 0);
    acts.delete();
    wgts.delete();
    clear_stats();
    tick(0, 0, 0, 0);
    checks++; if (bus.out_v !== 1'b0) begin errors++; $display("FAIL rmid_out_v: got %b expected 0", bus.out_v); end
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL rmid_out: got %h expected 0", bus.out); end
    repeat (4) acts.push_back(8'h22);
    repeat (12) wgts.push_back(16'h1111);
    for (int i = 0; i < 60 && !(fire_cyc.size() == 12 && got.size() == 3); i++) tick(0, 1, 1, 1);
    checks++; if (n_act != 4) begin errors++; $display("FAIL rmid_acts_taken: got %0d expected 4", n_act); end
    checks++; if (clr_cyc.size() != 3) begin errors++; $display("FAIL rmid_clr_count: got %0d expected 3", clr_cyc.size()); end
    if (clr_cyc.size() != 0 && fire_cyc.size() != 0) begin
      checks++; if (clr_cyc[0] != fire_cyc[0] + 1) begin errors++; $display("FAIL rmid_first_clr: got %0d expected %0d", clr_cyc[0], fire_cyc[0] + 1); end
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL rmid_results: got %0d expected 3", got.size()); end
    for (int f = 0; f < got.size(); f++) begin
      checks++; if (got[f] !== 32'h0010_0010) begin errors++; $display("FAIL rmid_val%0d: got %h expected 00100010", f, got[f]); end
    end
  endtask

  task automatic test_backpressure();
    res_t exp6 [6];
    exp6 = '{32'h0008_0008, 32'h0010_0010, 32'h0018_0018, 32'h0020_0020, 32'h0028_0028, 32'h0030_0030};
    clear_stats();
    load_folds(2);
    for (int i = 0; i < 40; i++) tick(0, 1, 1, 0);
    checks++; if (fire_cyc.size() != 19) begin errors++; $display("FAIL bp_stall_fires: got %0d expected 19", fire_cyc.size()); end
    checks++; if (bus.wgt_rdy !== 1'b0) begin errors++; $display("FAIL bp_wgt_rdy: got %b expected 0", bus.wgt_rdy); end
    checks++; if (bus.out_v !== 1'b1) begin errors++; $display("FAIL bp_out_v: got %b expected 1", bus.out_v); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", got.size()); end
    for (int i = 0; i < 60 && !(fire_cyc.size() == 24 && got.size() == 6); i++) tick(0, 1, 1, 1);
    checks++; if (fire_cyc.size() != 24) begin errors++; $display("FAIL bp_total_fires: got %0d expected 24", fire_cyc.size()); end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_results: got %0d expected 6", got.size()); end
    for (int f = 0; f < got.size() && f < 6; f++) begin
      checks++; if (got[f] !== exp6[f]) begin errors++; $display("FAIL bp_val%0d: got %h expected %h", f, got[f], exp6[f]); end
    end
  endtask

  task automatic test_pop_same_cycle();
    res_t exp6 [6];
    int   both, f0, g0;
    exp6 = '{32'h0008_0008, 32'h0010_0010, 32'h0018_0018, 32'h0020_0020, 32'h0028_0028, 32'h0030_0030};
    both = 0;
    clear_stats();
    load_folds(2);
    for (int i = 0; i < 40; i++) begin
      f0 = fire_cyc.size();
      g0 = got.size();
      tick(0, 1, 1, fire_cyc.size() == 15);
      if (fire_cyc.size() > f0 && got.size() > g0) both++;
    end
    checks++; if (both != 1) begin errors++; $display("FAIL psc_coincide: got %0d expected 1", both); end
    checks++; if (fire_cyc.size() != 23) begin errors++; $display("FAIL psc_stall_fires: got %0d expected 23", fire_cyc.size()); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL psc_popped: got %0d expected 1", got.size()); end
    for (int i = 0; i < 60 && !(fire_cyc.size() == 24 && got.size() == 6); i++) tick(0, 1, 1, 1);
    checks++; if (got.size() != 6) begin errors++; $display("FAIL psc_results: got %0d expected 6", got.size()); end
    for (int f = 0; f < got.size() && f < 6; f++) begin
      checks++; if (got[f] !== exp6[f]) begin errors++; $display("FAIL psc_val%0d: got %h expected %h", f, got[f], exp6[f]); end
    end
  endtask

  initial begin
    bus.in_v    = 1'b0;
    bus.in_act  = '0;
    bus.wgt_v   = 1'b0;
    bus.in_wgt  = '0;
    bus.out_rdy = 1'b0;
    clear_stats();
    test_reset();
    test_stream();
    test_weights_k();
    test_toggle();
    test_reset_mid();
    test_backpressure();
    test_pop_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
